// File: rtl/ucode_pkg.sv
// Shared definitions for the constant-pool index sequencer: state encoding,
// word geometry and the bound-check helper used when UCODE_CPIDX_BNDCHK_EN is set.
package ucode_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ0 = 2'd1,
        ST_REQ1 = 2'd2,
        ST_DONE = 2'd3
    } cp_state_e;

    localparam int unsigned CP_WORD_SHIFT = 2;
    localparam logic [31:0] CP_WORD_BYTES = 32'd4;

    // Last entry touched must lie below the pool length; 17 bits so index+1 cannot wrap.
    function automatic logic cp_oob_check(input logic [15:0] index,
                                          input logic [15:0] len,
                                          input logic        wide);
        logic [16:0] last_entry;
        last_entry = {1'b0, index} + {16'd0, wide};
        return (last_entry >= {1'b0, len});
    endfunction

endpackage

// File: rtl/ucode_cp_addr_gen.sv
// Constant-pool address generator: word-0 and word-1 byte addresses of an entry,
// both wrapping modulo 2^32.
module ucode_cp_addr_gen
    import ucode_pkg::*;
(
    input  logic [31:0] i_base,
    input  logic [15:0] i_index,
    output logic [31:0] o_addr0,
    output logic [31:0] o_addr1
);

    logic [31:0] w_offset;

    assign w_offset = {16'd0, i_index} << CP_WORD_SHIFT;
    assign o_addr0  = i_base + w_offset;
    assign o_addr1  = o_addr0 + CP_WORD_BYTES;

endmodule

// File: rtl/ucode_cpidx_seq.sv
// Constant-pool fetch sequencer: one- or two-word entry reads through the data cache.
// Optional bound check against cp_len is compiled in with UCODE_CPIDX_BNDCHK_EN.
module ucode_cpidx_seq
    import ucode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  index_byte1_e,
    input  logic [7:0]  index_byte2_e,
    input  logic        start_e,
    input  logic        wide_e,
    input  logic        iu_hold_e,
    input  logic [31:0] cp_base,
`ifdef UCODE_CPIDX_BNDCHK_EN
    input  logic [15:0] cp_len,
    output logic        cp_oob,
`endif
    output logic        dc_req,
    output logic [31:0] dc_addr,
    input  logic        dc_ack,
    input  logic [31:0] dc_data,
    output logic [31:0] cp_data0,
    output logic [31:0] cp_data1,
    output logic        cp_valid,
    output logic        busy
);

    cp_state_e   r_state;
    cp_state_e   w_next_state;
    logic [15:0] r_index;
    logic        r_wide;
    logic [31:0] r_base;
    logic [31:0] r_data0;
    logic [31:0] r_data1;
    logic [15:0] w_index_in;
    logic        w_accept;
    logic        w_oob_hit;
    logic        w_cap0;
    logic        w_cap1;
    logic [31:0] w_addr0;
    logic [31:0] w_addr1;

    assign w_index_in = {index_byte1_e, index_byte2_e};
    assign w_accept   = (r_state == ST_IDLE) && start_e && !iu_hold_e;

`ifdef UCODE_CPIDX_BNDCHK_EN
    logic r_oob;

    assign w_oob_hit = cp_oob_check(w_index_in, cp_len, wide_e);
    assign cp_oob    = r_oob;

    // Out-of-bounds flag: set or cleared by every accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_oob <= 1'b0;
        end else if (w_accept) begin
            r_oob <= w_oob_hit;
        end
    end
`else
    assign w_oob_hit = 1'b0;
`endif

    ucode_cp_addr_gen u_addr_gen (
        .i_base  (r_base),
        .i_index (r_index),
        .o_addr0 (w_addr0),
        .o_addr1 (w_addr1)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and capture strobes; acks count only while requesting.
    always_comb begin
        w_next_state = r_state;
        w_cap0       = 1'b0;
        w_cap1       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_oob_hit ? ST_DONE : ST_REQ0;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_REQ0: begin
                if (dc_ack) begin
                    w_cap0       = 1'b1;
                    w_next_state = r_wide ? ST_REQ1 : ST_DONE;
                end else begin
                    w_next_state = ST_REQ0;
                end
            end
            ST_REQ1: begin
                if (dc_ack) begin
                    w_cap1       = 1'b1;
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_REQ1;
                end
            end
            ST_DONE: begin
                if (!iu_hold_e) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DONE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Request latches and entry data; a rejected (out-of-bounds) entry reads as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_index <= 16'd0;
            r_wide  <= 1'b0;
            r_base  <= 32'd0;
            r_data0 <= 32'd0;
            r_data1 <= 32'd0;
        end else if (w_accept) begin
            r_index <= w_index_in;
            r_wide  <= wide_e;
            r_base  <= cp_base;
            if (w_oob_hit) begin
                r_data0 <= 32'd0;
                r_data1 <= 32'd0;
            end else if (!wide_e) begin
                r_data1 <= 32'd0;
            end
        end else if (w_cap0) begin
            r_data0 <= dc_data;
        end else if (w_cap1) begin
            r_data1 <= dc_data;
        end
    end

    // Outputs decode purely from registered state and latched request fields.
    always_comb begin
        dc_req   = 1'b0;
        dc_addr  = 32'd0;
        cp_valid = 1'b0;
        busy     = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_REQ0: begin
                dc_req  = 1'b1;
                dc_addr = w_addr0;
            end
            ST_REQ1: begin
                dc_req  = 1'b1;
                dc_addr = w_addr1;
            end
            ST_DONE: begin
                cp_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign cp_data0 = r_data0;
    assign cp_data1 = r_data1;

endmodule

// File: tb/tb_ucode_cpidx_seq.sv
// Bench for ucode_cpidx_seq: directed vector table, hand sequences for stall/hold,
// wrap/reset and bound check, then random traffic against a queue-based model.
module tb_ucode_cpidx_seq;

    logic        clk;
    logic        reset;
    logic [7:0]  index_byte1_e;
    logic [7:0]  index_byte2_e;
    logic        start_e;
    logic        wide_e;
    logic        iu_hold_e;
    logic [31:0] cp_base;
    logic        dc_req;
    logic [31:0] dc_addr;
    logic        dc_ack;
    logic [31:0] dc_data;
    logic [31:0] cp_data0;
    logic [31:0] cp_data1;
    logic        cp_valid;
    logic        busy;
`ifdef UCODE_CPIDX_BNDCHK_EN
    logic [15:0] cp_len;
    logic        cp_oob;
`endif

    int n_vec;
    int n_err;

    ucode_cpidx_seq dut (
        .clk           (clk),
        .reset         (reset),
        .index_byte1_e (index_byte1_e),
        .index_byte2_e (index_byte2_e),
        .start_e       (start_e),
        .wide_e        (wide_e),
        .iu_hold_e     (iu_hold_e),
        .cp_base       (cp_base),
`ifdef UCODE_CPIDX_BNDCHK_EN
        .cp_len        (cp_len),
        .cp_oob        (cp_oob),
`endif
        .dc_req        (dc_req),
        .dc_addr       (dc_addr),
        .dc_ack        (dc_ack),
        .dc_data       (dc_data),
        .cp_data0      (cp_data0),
        .cp_data1      (cp_data1),
        .cp_valid      (cp_valid),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        wide;
        logic        hold;
        logic        ack;
        logic [15:0] idx;
        logic [31:0] base;
        logic [31:0] data;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic        bsy;
        logic [31:0] d0;
        logic [31:0] d1;
    } vec_t;

    vec_t tbl[9];

    // Reference model: a queue of outstanding word fetches plus a "done" flag.
    logic [31:0] mq_addr[$];
    int          mq_slot[$];
    bit          m_done;
    logic [31:0] m_d0;
    logic [31:0] m_d1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic req, input logic [31:0] addr,
                              input logic valid, input logic bsy,
                              input logic [31:0] d0, input logic [31:0] d1);
        chk({tag, ".dc_req"},   {31'd0, dc_req},   {31'd0, req});
        chk({tag, ".dc_addr"},  dc_addr,           addr);
        chk({tag, ".cp_valid"}, {31'd0, cp_valid}, {31'd0, valid});
        chk({tag, ".busy"},     {31'd0, busy},     {31'd0, bsy});
        chk({tag, ".cp_data0"}, cp_data0,          d0);
        chk({tag, ".cp_data1"}, cp_data1,          d1);
    endtask

    task automatic apply(input logic s, input logic w, input logic h, input logic a,
                         input logic [15:0] ix, input logic [31:0] b, input logic [31:0] d);
        start_e       = s;
        wide_e        = w;
        iu_hold_e     = h;
        dc_ack        = a;
        index_byte1_e = ix[15:8];
        index_byte2_e = ix[7:0];
        cp_base       = b;
        dc_data       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic model_edge(input logic s, input logic w, input logic h, input logic a,
                              input logic [15:0] ix, input logic [31:0] b, input logic [31:0] d);
        logic [31:0] a0;
        if (mq_addr.size() > 0) begin
            if (a) begin
                if (mq_slot[0] == 0) m_d0 = d;
                else                 m_d1 = d;
                void'(mq_addr.pop_front());
                void'(mq_slot.pop_front());
                if (mq_addr.size() == 0) m_done = 1'b1;
            end
        end else if (m_done) begin
            if (!h) m_done = 1'b0;
        end else if (s && !h) begin
            a0 = b + {16'd0, ix} * 32'd4;
            mq_addr.push_back(a0);
            mq_slot.push_back(0);
            if (w) begin
                mq_addr.push_back(a0 + 32'd4);
                mq_slot.push_back(1);
            end else begin
                m_d1 = 32'd0;
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        start_e = 1'b0; wide_e = 1'b0; iu_hold_e = 1'b0; dc_ack = 1'b0;
        index_byte1_e = 8'd0; index_byte2_e = 8'd0; cp_base = 32'd0; dc_data = 32'd0;
`ifdef UCODE_CPIDX_BNDCHK_EN
        cp_len = 16'hFFFF;
`endif

        // Reset state, before any clock edge.
        #1;
        check_outs("reset", 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        //            st   wd   hd   ak   idx       base          data           req  addr          vld  bsy  d0            d1
        tbl[0] = '{1'b1,1'b0,1'b0,1'b1,16'h0003,32'h0000_1000,32'hDEAD_0000, 1'b1,32'h0000_100C,1'b0,1'b1,32'h0,        32'h0};
        tbl[1] = '{1'b0,1'b0,1'b0,1'b1,16'h0003,32'h0000_1000,32'hA5A5_0001, 1'b0,32'h0,        1'b1,1'b1,32'hA5A5_0001,32'h0};
        tbl[2] = '{1'b0,1'b0,1'b0,1'b0,16'h0000,32'h0,        32'h0,         1'b0,32'h0,        1'b0,1'b0,32'hA5A5_0001,32'h0};
        tbl[3] = '{1'b1,1'b1,1'b0,1'b0,16'h00FF,32'h0000_2000,32'h0,         1'b1,32'h0000_23FC,1'b0,1'b1,32'hA5A5_0001,32'h0};
        tbl[4] = '{1'b0,1'b0,1'b0,1'b1,16'h0001,32'h9999_0000,32'h1111_1111, 1'b1,32'h0000_2400,1'b0,1'b1,32'h1111_1111,32'h0};
        tbl[5] = '{1'b0,1'b0,1'b0,1'b1,16'h0001,32'h9999_0000,32'h2222_2222, 1'b0,32'h0,        1'b1,1'b1,32'h1111_1111,32'h2222_2222};
        tbl[6] = '{1'b0,1'b0,1'b0,1'b1,16'h0000,32'h0,        32'hBAD0_0BAD, 1'b0,32'h0,        1'b0,1'b0,32'h1111_1111,32'h2222_2222};
        tbl[7] = '{1'b0,1'b0,1'b0,1'b1,16'h0000,32'h0,        32'hBAD1_1BAD, 1'b0,32'h0,        1'b0,1'b0,32'h1111_1111,32'h2222_2222};
        tbl[8] = '{1'b1,1'b0,1'b1,1'b0,16'h0004,32'h0000_4000,32'h0,         1'b0,32'h0,        1'b0,1'b0,32'h1111_1111,32'h2222_2222};

        for (int i = 0; i < 9; i++) begin
            apply(tbl[i].start, tbl[i].wide, tbl[i].hold, tbl[i].ack, tbl[i].idx, tbl[i].base, tbl[i].data);
            check_outs($sformatf("tbl%0d", i), tbl[i].req, tbl[i].addr, tbl[i].valid, tbl[i].bsy,
                       tbl[i].d0, tbl[i].d1);
        end

        // Stall and hold: address stable through missing acks, starts ignored while busy.
        apply(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 32'h0000_3000, 32'h0);
        check_outs("stall.start", 1'b1, 32'h0000_3040, 1'b0, 1'b1, 32'h1111_1111, 32'h0);
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0, 16'h0020, 32'h0000_5000, 32'h0);
            check_outs($sformatf("stall.wait%0d", k), 1'b1, 32'h0000_3040, 1'b0, 1'b1, 32'h1111_1111, 32'h0);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 32'h0, 32'hCAFE_F00D);
        check_outs("stall.ack", 1'b0, 32'h0, 1'b1, 1'b1, 32'hCAFE_F00D, 32'h0);
        for (int k = 0; k < 2; k++) begin
            apply(1'b1, 1'b0, 1'b1, 1'b1, 16'h0, 32'h0, 32'h0BAD_0BAD);
            check_outs($sformatf("stall.hold%0d", k), 1'b0, 32'h0, 1'b1, 1'b1, 32'hCAFE_F00D, 32'h0);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0);
        check_outs("stall.release", 1'b0, 32'h0, 1'b0, 1'b0, 32'hCAFE_F00D, 32'h0);

`ifdef UCODE_CPIDX_BNDCHK_EN
        // Bound check: wide entry at the last index is rejected without a cache access.
        cp_len = 16'd4;
        apply(1'b1, 1'b1, 1'b0, 1'b0, 16'h0003, 32'h0000_0100, 32'h0);
        check_outs("oob.wide", 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0);
        chk("oob.wide.cp_oob", {31'd0, cp_oob}, 32'd1);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0);
        chk("oob.idle.cp_oob", {31'd0, cp_oob}, 32'd1);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 32'h0000_0100, 32'h0);
        check_outs("oob.narrow", 1'b1, 32'h0000_010C, 1'b0, 1'b1, 32'h0, 32'h0);
        chk("oob.narrow.cp_oob", {31'd0, cp_oob}, 32'd0);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 32'h0, 32'h0000_0055);
        check_outs("oob.narrow.ack", 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0055, 32'h0);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0);
        cp_len = 16'hFFFF;
`endif

        // Address wrap, then asynchronous reset in REQ1 and a stale ack afterwards.
        apply(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 32'hFFFF_FFFC, 32'h0);
        chk("wrap.addr0", dc_addr, 32'hFFFF_FFFC);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 32'h0, 32'h1234_5678);
        chk("wrap.addr1", dc_addr, 32'h0000_0000);
        chk("wrap.req1", {31'd0, dc_req}, 32'd1);
        chk("wrap.d0", cp_data0, 32'h1234_5678);
        #2;
        reset = 1'b1;
        #1;
        check_outs("rst.async", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
`ifdef UCODE_CPIDX_BNDCHK_EN
        chk("rst.async.cp_oob", {31'd0, cp_oob}, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        apply(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 32'h0, 32'h9999_9999);
        check_outs("rst.late_ack", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Random traffic against the model, which starts from the reset state.
        m_done = 1'b0;
        m_d0   = 32'd0;
        m_d1   = 32'd0;
        for (int c = 0; c < 400; c++) begin
            logic        s, w, h, a;
            logic [15:0] ix;
            logic [31:0] b, d;
            s  = ($urandom % 3) == 0;
            w  = $urandom % 2;
            h  = ($urandom % 4) == 0;
            a  = $urandom % 2;
            ix = 16'($urandom_range(0, 32'h7FFF));
            b  = $urandom & 32'hFFFF_FFFC;
            d  = $urandom;
            model_edge(s, w, h, a, ix, b, d);
            apply(s, w, h, a, ix, b, d);
            check_outs($sformatf("rnd%0d", c), mq_addr.size() > 0,
                       (mq_addr.size() > 0) ? mq_addr[0] : 32'd0,
                       m_done, (mq_addr.size() > 0) || m_done, m_d0, m_d1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
